rs232_echo_fifo: RTL

Buffering stage between the RS232 receiver and transmitter. Accepts complete 10-bit frames from the receiver, checks framing, stores data bytes in a circular FIFO, and re-frames each byte for the transmitter through a request/started/done handshake. Decouples receive bursts from transmitter occupancy so no byte is lost while the transmitter is busy.

---
 rtl/rs232_echo_fifo.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/rs232_echo_fifo.sv
// -----------------------------------------------------------------------------
// rs232_echo_fifo
//
// Buffering stage between an RS232 receiver and transmitter. Complete 10-bit
// frames from the receiver are checked, and their data bytes are stored in a
// circular FIFO. A small FSM pops one byte at a time, re-frames it as
// {stop=1, data, start=0} and hands it to the transmitter through a
// request/started/done handshake. Receive bursts can therefore arrive while
// the transmitter is still busy.
//
// Handshake semantics (transmitter side):
//   tx_req_o is raised together with a new tx_frame_o and held until the
//   one-cycle tx_started_i pulse, which means the transmitter has latched
//   tx_frame_o. tx_frame_o stays stable until the next pop. The one-cycle
//   tx_done_i pulse ends the transfer; it is only honoured in WAIT_DONE.
//   The receiver side has no back-pressure: rx_valid_i is a one-cycle strobe.
//
// Optional feature (macro FRAME_CHECK_EN):
//   defined   - frames with a bad start or stop bit are discarded and set the
//               sticky frame_err_o flag.
//   undefined - every frame is stored; frame_err_o is tied to 0.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         synchronous, active-low reset
//   rx_frame_i    received frame: [0] start, [8:1] data LSB-first, [9] stop
//   rx_valid_i    one-cycle strobe, rx_frame_i valid
//   tx_frame_o    frame for the transmitter
//   tx_req_o      transmit request, held until tx_started_i
//   tx_started_i  transmitter latched tx_frame_o (pulse)
//   tx_done_i     transmitter finished the frame (pulse)
//   count_o       number of stored bytes
//   empty_o       count_o == 0
//   full_o        count_o == 2**DEPTH_LOG2
//   overrun_o     sticky: a frame was dropped because the FIFO was full
//   frame_err_o   sticky: a frame with a bad start/stop bit was received
//   err_clr_i     clears overrun_o and frame_err_o (a same-cycle set wins)
//   state_o       current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module rs232_echo_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [9:0]            rx_frame_i,
    input  logic                  rx_valid_i,
    output logic [9:0]            tx_frame_o,
    output logic                  tx_req_o,
    input  logic                  tx_started_i,
    input  logic                  tx_done_i,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overrun_o,
    output logic                  frame_err_o,
    input  logic                  err_clr_i,
    output logic [1:0]            state_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_START = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE  = 2'd2;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [1:0]            state;

    logic frame_ok;
    logic push_req;
    logic push;
    logic pop;
    logic overrun_set;

    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == FULL_COUNT);
    assign state_o = state;

`ifdef FRAME_CHECK_EN
    logic frame_err_set;

    assign frame_ok      = (rx_frame_i[0] == 1'b0) && (rx_frame_i[9] == 1'b1);
    assign frame_err_set = rx_valid_i && !frame_ok;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            frame_err_o <= 1'b0;
        end else if (frame_err_set) begin
            frame_err_o <= 1'b1;
        end else if (err_clr_i) begin
            frame_err_o <= 1'b0;
        end
    end
`else
    // Start/stop bits are intentionally ignored in this build.
    logic unused_frame_bits;

    assign unused_frame_bits = rx_frame_i[0] ^ rx_frame_i[9];
    assign frame_ok          = 1'b1;
    assign frame_err_o       = 1'b0;
`endif

    // A pop frees a slot in the same edge, so a push into a full FIFO is
    // still accepted when the FSM pops in that cycle.
    assign pop         = (state == ST_IDLE) && !empty_o;
    assign push_req    = rx_valid_i && frame_ok;
    assign push        = push_req && (!full_o || pop);
    assign overrun_set = push_req && full_o && !pop;

    // Storage needs no reset; only the pointers define its contents. When
    // full, wr_ptr == rd_ptr: the popped byte is read before the write lands.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= rx_frame_i[8:1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            overrun_o <= 1'b0;
        end else if (overrun_set) begin
            overrun_o <= 1'b1;
        end else if (err_clr_i) begin
            overrun_o <= 1'b0;
        end
    end

    // Transmit FSM. A done pulse arriving together with started in
    // WAIT_START is not consumed; the FSM then waits for a later done.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= ST_IDLE;
            tx_req_o   <= 1'b0;
            tx_frame_o <= 10'h3FF;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        tx_frame_o <= {1'b1, mem[rd_ptr], 1'b0};
                        tx_req_o   <= 1'b1;
                        state      <= ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    if (tx_started_i) begin
                        tx_req_o <= 1'b0;
                        state    <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_done_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    tx_req_o <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
